// File: rtl/nes_pad_pkg.sv
// Shared types for the NES pad bus scheduler: key codes, button bit
// positions, event record layout and the bus sequencer states.
package nes_pad_pkg;

    typedef enum logic [3:0] {
        KEY_NONE  = 4'd0,
        KEY_UP    = 4'd1,
        KEY_DN    = 4'd2,
        KEY_LT    = 4'd3,
        KEY_RT    = 4'd4,
        KEY_A     = 4'd5,
        KEY_B     = 4'd6,
        KEY_SEL   = 4'd7,
        KEY_START = 4'd8
    } key_e;

    // Bit positions inside state0/state1 (order the pads shift them out)
    localparam logic [2:0] BTN_A     = 3'd0;
    localparam logic [2:0] BTN_B     = 3'd1;
    localparam logic [2:0] BTN_SEL   = 3'd2;
    localparam logic [2:0] BTN_START = 3'd3;
    localparam logic [2:0] BTN_UP    = 3'd4;
    localparam logic [2:0] BTN_DN    = 3'd5;
    localparam logic [2:0] BTN_LT    = 3'd6;
    localparam logic [2:0] BTN_RT    = 3'd7;

    localparam int unsigned SCAN_LEN = 16;

    typedef struct packed {
        logic pad;
        logic press;
        key_e key;
    } evt_t;

    localparam int unsigned EVT_W = $bits(evt_t);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_SCAN
    } state_e;

    function automatic key_e bit_to_key(input logic [2:0] idx);
        key_e k;
        case (idx)
            BTN_A:     k = KEY_A;
            BTN_B:     k = KEY_B;
            BTN_SEL:   k = KEY_SEL;
            BTN_START: k = KEY_START;
            BTN_UP:    k = KEY_UP;
            BTN_DN:    k = KEY_DN;
            BTN_LT:    k = KEY_LT;
            default:   k = KEY_RT;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/nes_evt_fifo.sv
// Small synchronous event FIFO with valid/ready style output. A push is
// accepted when there is room or when the head is popped in the same cycle.
module nes_evt_fifo
    import nes_pad_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [EVT_W-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [EVT_W-1:0] data_o,
    output logic             full_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [EVT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic             pop_ok;
    logic             push_ok;

    assign valid_o = (cnt_q != '0);
    assign full_o  = (cnt_q == CNT_FULL);
    assign data_o  = mem_q[rd_q];
    assign pop_ok  = pop_i && valid_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Storage array; written only on an accepted push
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_q] <= data_i;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_q <= rd_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/nes_pad_scheduler.sv
// Single owner of the shared NES pad bus: periodic latch pulse, 7 serial
// clocks, parallel sampling of both pads, then a 16-cycle scan that turns
// button changes into press/release events queued for the game logic.
// Optional feature: define DEBOUNCE_EN to accept a change only after two
// consecutive identical frames.
module nes_pad_scheduler
    import nes_pad_pkg::*;
#(
    parameter int unsigned SER_DIV    = 256,
    parameter int unsigned FRAME_DIV  = 262144,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] state0,
    output logic [7:0] state1,
    output logic       frame_done,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic       evt_pad,
    output logic       evt_press,
    output logic [3:0] evt_key,
    output logic       overflow
);

    localparam int unsigned TW   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int unsigned PMAX = (2 * SER_DIV > SCAN_LEN) ? 2 * SER_DIV : SCAN_LEN;
    localparam int unsigned PW   = $clog2(PMAX);

    state_e           state_q, state_d;
    logic [TW-1:0]    timer_q;
    logic             tick;
    logic [PW-1:0]    phase_q, phase_d;
    logic             phase_last;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       samp0_q, samp0_d, samp1_q, samp1_d;
    logic [7:0]       state0_q, state0_d, state1_q, state1_d;
    logic             latch_q, pclk_q, done_q, ovf_q;
    logic [7:0]       acc0, acc1;
    logic [3:0]       scan_idx;
    logic             scan_pad, scan_new, scan_cur, scan_acc, scan_end;
    logic [2:0]       scan_bit;
    logic             push, pop, full;
    evt_t             push_evt, head_evt;
    logic [EVT_W-1:0] push_data, head_data;

    assign tick = (timer_q == TW'(FRAME_DIV - 1));

    // Free-running frame timer, wraps modulo FRAME_DIV
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else if (tick) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 1'b1;
        end
    end

    // Last cycle of the current phase
    always_comb begin
        phase_last = 1'b0;
        case (state_q)
            ST_LATCH:                 phase_last = (phase_q == PW'(2 * SER_DIV - 1));
            ST_SHIFT_LO, ST_SHIFT_HI: phase_last = (phase_q == PW'(SER_DIV - 1));
            ST_SCAN:                  phase_last = (phase_q == PW'(SCAN_LEN - 1));
            default:                  phase_last = 1'b0;
        endcase
    end

    // Bus sequencer next state, phase/bit counters and pad sampling
    always_comb begin
        state_d = state_q;
        phase_d = phase_q + 1'b1;
        bit_d   = bit_q;
        samp0_d = samp0_q;
        samp1_d = samp1_q;
        case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                bit_d   = '0;
                if (tick && enable) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (phase_last) begin
                    samp0_d[0] = ~pad_data[0];
                    samp1_d[0] = ~pad_data[1];
                    phase_d    = '0;
                    bit_d      = 3'd1;
                    state_d    = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                if (phase_last) begin
                    phase_d = '0;
                    state_d = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (phase_last) begin
                    samp0_d[bit_q] = ~pad_data[0];
                    samp1_d[bit_q] = ~pad_data[1];
                    phase_d        = '0;
                    if (bit_q == 3'd7) begin
                        state_d = ST_SCAN;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        state_d = ST_SHIFT_LO;
                    end
                end
            end
            ST_SCAN: begin
                if (phase_last) begin
                    phase_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                phase_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef DEBOUNCE_EN
    logic [7:0] prev0_q, prev1_q;

    // Previous frame's raw samples, used to qualify changes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev0_q <= '0;
            prev1_q <= '0;
        end else if (scan_end) begin
            prev0_q <= samp0_q;
            prev1_q <= samp1_q;
        end
    end

    assign acc0 = ~(samp0_q ^ prev0_q);
    assign acc1 = ~(samp1_q ^ prev1_q);
`else
    assign acc0 = '1;
    assign acc1 = '1;
`endif

    // Scan walks pad0 bits 0..7 then pad1 bits 0..7, one per cycle
    always_comb begin
        scan_idx  = phase_q[3:0];
        scan_pad  = scan_idx[3];
        scan_bit  = scan_idx[2:0];
        scan_new  = scan_pad ? samp1_q[scan_bit]  : samp0_q[scan_bit];
        scan_cur  = scan_pad ? state1_q[scan_bit] : state0_q[scan_bit];
        scan_acc  = scan_pad ? acc1[scan_bit]     : acc0[scan_bit];
        scan_end  = (state_q == ST_SCAN) && phase_last;
        push      = (state_q == ST_SCAN) && scan_acc && (scan_new != scan_cur);
        push_evt  = '{pad: scan_pad, press: scan_new, key: bit_to_key(scan_bit)};
        push_data = push_evt;
        state0_d  = state0_q;
        state1_d  = state1_q;
        if (scan_end) begin
            state0_d = (samp0_q & acc0) | (state0_q & ~acc0);
            state1_d = (samp1_q & acc1) | (state1_q & ~acc1);
        end
    end

    assign pop = evt_valid && evt_ready;

    // Sequencer registers; bus lines are registered from the next state so they never glitch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            bit_q    <= '0;
            samp0_q  <= '0;
            samp1_q  <= '0;
            state0_q <= '0;
            state1_q <= '0;
            latch_q  <= 1'b0;
            pclk_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            samp0_q  <= samp0_d;
            samp1_q  <= samp1_d;
            state0_q <= state0_d;
            state1_q <= state1_d;
            latch_q  <= (state_d == ST_LATCH);
            pclk_q   <= (state_d == ST_SHIFT_HI);
            done_q   <= scan_end;
            ovf_q    <= ovf_q | (push && full && !pop);
        end
    end

    nes_evt_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk),
        .rst_ni (reset),
        .push_i (push),
        .data_i (push_data),
        .pop_i  (evt_ready),
        .valid_o(evt_valid),
        .data_o (head_data),
        .full_o (full)
    );

    assign head_evt   = evt_t'(head_data);
    assign evt_pad    = head_evt.pad;
    assign evt_press  = head_evt.press;
    assign evt_key    = head_evt.key;
    assign pad_latch  = latch_q;
    assign pad_clk    = pclk_q;
    assign state0     = state0_q;
    assign state1     = state1_q;
    assign frame_done = done_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_nes_pad_scheduler.sv
// Self-checking bench for nes_pad_scheduler: pad shift-register model,
// reference model of button state/events, event scoreboard.
module tb_nes_pad_scheduler;

    localparam int unsigned SER_DIV    = 2;
    localparam int unsigned FRAME_DIV  = 128;
    localparam int unsigned FIFO_DEPTH = 4;
`ifdef DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] pad_data;
    logic       pad_latch, pad_clk;
    logic [7:0] state0, state1;
    logic       frame_done, evt_valid, evt_ready, evt_pad, evt_press, overflow;
    logic [3:0] evt_key;

    nes_pad_scheduler #(
        .SER_DIV   (SER_DIV),
        .FRAME_DIV (FRAME_DIV),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .pad_data  (pad_data),
        .pad_latch (pad_latch),
        .pad_clk   (pad_clk),
        .state0    (state0),
        .state1    (state1),
        .frame_done(frame_done),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_pad   (evt_pad),
        .evt_press (evt_press),
        .evt_key   (evt_key),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pad model: 4021-style parallel load on latch, shift on pad_clk rise
    logic [7:0] pat0 = '0, pat1 = '0;
    logic [7:0] sr0 = '1, sr1 = '1;
    always @(posedge pad_clk or posedge pad_latch) begin
        if (pad_latch) begin
            sr0 = ~pat0;
            sr1 = ~pat1;
        end else begin
            sr0 = {1'b1, sr0[7:1]};
            sr1 = {1'b1, sr1[7:1]};
        end
    end
    assign pad_data = {sr1[0], sr0[0]};

    // Reference model
    logic [3:0] keytab [8] = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd1, 4'd2, 4'd3, 4'd4};
    logic [7:0] m_st [2];
    logic [7:0] m_prev [2];
    logic       m_ovf;
    logic [5:0] sb [$];

    task automatic model_reset();
        m_st[0] = '0;   m_st[1] = '0;
        m_prev[0] = '0; m_prev[1] = '0;
        m_ovf = 1'b0;
        sb.delete();
    endtask

    task automatic model_frame(input logic [7:0] p0, input logic [7:0] p1);
        logic [7:0] p [2];
        logic acc, nb;
        p[0] = p0;
        p[1] = p1;
        for (int pd = 0; pd < 2; pd++) begin
            for (int b = 0; b < 8; b++) begin
                acc = DEB ? (p[pd][b] == m_prev[pd][b]) : 1'b1;
                nb  = acc ? p[pd][b] : m_st[pd][b];
                if (nb != m_st[pd][b]) begin
                    if (!evt_ready && sb.size() >= FIFO_DEPTH) m_ovf = 1'b1;
                    else sb.push_back({(pd == 1), nb, keytab[b]});
                end
                m_st[pd][b] = nb;
            end
        end
        m_prev[0] = p0;
        m_prev[1] = p1;
    endtask

    // Monitor: event scoreboard and bus activity counters
    int lat_cyc = 0, pclk_cyc = 0, pclk_rise = 0, fd_cnt = 0, pop_cnt = 0;
    logic pclk_prev = 1'b0;
    logic [5:0] exp_evt;
    always @(negedge clk) begin
        if (reset) begin
            if (evt_valid && evt_ready) begin
                if (sb.size() == 0) begin
                    check_eq("evt_unexpected", {31'd0, evt_valid}, 32'd0);
                end else begin
                    exp_evt = sb.pop_front();
                    check_eq("evt", {26'd0, evt_pad, evt_press, evt_key}, {26'd0, exp_evt});
                end
                pop_cnt++;
            end
            if (pad_latch) lat_cyc++;
            if (pad_clk) pclk_cyc++;
            if (pad_clk && !pclk_prev) pclk_rise++;
            if (frame_done) fd_cnt++;
        end
        pclk_prev = pad_clk;
    end

    task automatic run_frame(input string tag, input logic [7:0] p0, input logic [7:0] p1,
                             input bit drop_en);
        int l0, c0, r0, f0;
        bit got;
        pat0 = p0;
        pat1 = p1;
        model_frame(p0, p1);
        l0 = lat_cyc; c0 = pclk_cyc; r0 = pclk_rise; f0 = fd_cnt;
        if (drop_en) begin
            got = 0;
            for (int i = 0; i < 400; i++) begin
                @(posedge clk); #1;
                if (pad_latch) begin got = 1; break; end
            end
            check_eq({tag, "_latch_seen"}, {31'd0, got}, 32'd1);
            enable = 1'b0;
        end
        got = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (frame_done) begin got = 1; break; end
        end
        check_eq({tag, "_frame_done"}, {31'd0, got}, 32'd1);
        repeat (4) @(negedge clk);
        check_eq({tag, "_state0"}, {24'd0, state0}, {24'd0, m_st[0]});
        check_eq({tag, "_state1"}, {24'd0, state1}, {24'd0, m_st[1]});
        check_eq({tag, "_overflow"}, {31'd0, overflow}, {31'd0, m_ovf});
        check_eq({tag, "_latch_cycles"}, lat_cyc - l0, 2 * SER_DIV);
        check_eq({tag, "_clk_pulses"}, pclk_rise - r0, 7);
        check_eq({tag, "_clk_high_cycles"}, pclk_cyc - c0, 7 * SER_DIV);
        check_eq({tag, "_done_pulses"}, fd_cnt - f0, 1);
        if (evt_ready) check_eq({tag, "_events_left"}, sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int l0;
        bit got;
        reset = 1'b0;
        enable = 1'b1;
        evt_ready = 1'b1;
        model_reset();
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_eq("rst_latch", {31'd0, pad_latch}, 32'd0);
        check_eq("rst_clk", {31'd0, pad_clk}, 32'd0);
        check_eq("rst_state0", {24'd0, state0}, 32'd0);
        check_eq("rst_state1", {24'd0, state1}, 32'd0);
        check_eq("rst_valid", {31'd0, evt_valid}, 32'd0);
        check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
        check_eq("rst_done", {31'd0, frame_done}, 32'd0);

        // pad0 A held
        run_frame("t2a", 8'h01, 8'h00, 0);
        run_frame("t2b", 8'h01, 8'h00, 0);
        // pad0 releases A, pad1 presses RIGHT
        run_frame("t3a", 8'h00, 8'h80, 0);
        run_frame("t3b", 8'h00, 8'h80, 0);

        // queue fills while consumer stalls
        @(posedge clk); #1 evt_ready = 1'b0;
        run_frame("t4a", 8'h70, 8'h03, 0);
        run_frame("t4b", 8'h70, 8'h03, 0);
        check_eq("t4_queued_valid", {31'd0, evt_valid}, 32'd1);
        check_eq("t4_model_queued", sb.size(), FIFO_DEPTH);
        p0 = pop_cnt;
        @(posedge clk); #1 evt_ready = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("t4_drain_pops", pop_cnt - p0, FIFO_DEPTH);
        check_eq("t4_drain_valid", {31'd0, evt_valid}, 32'd0);
        check_eq("t4_drain_left", sb.size(), 0);

        // pad0 B pressed for a single frame
        run_frame("t5a", 8'h72, 8'h03, 0);
        run_frame("t5b", 8'h70, 8'h03, 0);

        // reset while pad_clk is high
        pat0 = 8'h08;
        pat1 = 8'h10;
        got = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (pad_clk) begin got = 1; break; end
        end
        check_eq("t1_shift_hi_seen", {31'd0, got}, 32'd1);
        reset = 1'b0;
        #1;
        check_eq("t1_latch", {31'd0, pad_latch}, 32'd0);
        check_eq("t1_clk", {31'd0, pad_clk}, 32'd0);
        check_eq("t1_valid", {31'd0, evt_valid}, 32'd0);
        check_eq("t1_state0", {24'd0, state0}, 32'd0);
        check_eq("t1_state1", {24'd0, state1}, 32'd0);
        check_eq("t1_overflow", {31'd0, overflow}, 32'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        run_frame("t1post", 8'h08, 8'h10, 0);

        // enable dropped during the latch pulse
        run_frame("t6", 8'h08, 8'h10, 1);
        l0 = lat_cyc;
        repeat (300) @(negedge clk);
        check_eq("t6_no_latch", lat_cyc - l0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
